display_receiver_module: RTL and testbench
==========================================

// Module: display_receiver_module
// PURPOSE
//   Receiving end of the serial display link driven by display_module.
//   Samples VALUE_SIGNAL/ENABLE_SIGNAL on DATA_CLOCK_SIGNAL falling edges and rebuilds the 4*WORDS-bit BCD word.
//   Checks frame length and BCD digit validity, then presents the word with a one-cycle VALID strobe.
//   Sits on the display board / loopback bench, clocked by internal_clock.
// PARAMETERS
//   WORDS        4  number of BCD digits per frame; frame length N = 4*WORDS bits
//   SYNC_STAGES  2  synchronizer flops on each serial input (>=2)
// PORTS
//   internal_clock      in   1          system clock; all logic on its posedge
//   RST                 in   1          synchronous, active-high reset
//   VALUE_SIGNAL        in   1          serial data bit
//   ENABLE_SIGNAL       in   1          frame-active qualifier
//   DATA_CLOCK_SIGNAL   in   1          serial bit clock (much slower than internal_clock)
//   VALUE_BCD_OUT       out  4*WORDS    last valid received word, digit i at [4i+3:4i]
//   VALID               out  1          1-cycle pulse: VALUE_BCD_OUT just updated
//   FRAME_ERROR         out  1          1-cycle pulse: frame shorter or longer than N bits
//   DIGIT_ERROR         out  1          1-cycle pulse: complete frame held a digit > 9
//   BUSY                out  1          high while a frame is being received (RECV/DONE/WAIT_LOW)
// BEHAVIOUR
//   Reset: VALUE_BCD_OUT=0, VALID=FRAME_ERROR=DIGIT_ERROR=BUSY=0, state=IDLE, bit count=0.
//   Reset: synchronizer and edge-detect flops=0, shift register=0. Reset mid-frame discards the partial frame.
//   Input path: all three inputs pass through SYNC_STAGES flops.
//   A sample event is a 1->0 transition of synced DATA_CLOCK (registered previous value).
//   The transmitter changes data just after the rising edge, so falling-edge sampling is mid-bit.
//   Bit map: k-th bit of a frame (k=0..N-1) goes to index (3 - k%4) + (k/4)*4.
//   This places digit 0 first, MSB first within each digit.
//   States (sample events only; no other transitions):
//     IDLE: EN=1 -> store bit 0, cnt=1, go RECV. EN=0 -> stay.
//     RECV: EN=1 -> store bit cnt, cnt++; at cnt==N go DONE.
//           EN=0 (cnt<N) -> FRAME_ERROR pulse, go IDLE.
//     DONE: EN=0 -> digit check. All digits <=9: VALUE_BCD_OUT<=shift reg, VALID pulse.
//           Otherwise DIGIT_ERROR pulse, output held. Either way go IDLE.
//           EN=1 (bit N+1) -> FRAME_ERROR pulse, go WAIT_LOW.
//     WAIT_LOW: ignore data until EN=0 sample, then go IDLE (no extra pulse).
//   VALID, FRAME_ERROR and DIGIT_ERROR are mutually exclusive, each exactly one cycle wide.
//   Each is asserted SYNC_STAGES+2 internal_clock cycles after the triggering DATA_CLOCK fall.
//   VALUE_BCD_OUT changes only together with VALID; otherwise it holds.
//   A frame starting on the sample right after DONE->IDLE is accepted (no mandatory idle gap).
//   cnt width = $clog2(N+1); never wraps (bounded by DONE).
// TESTING  (WORDS=4; bench transmitter model, DATA_CLOCK half-period 8 cycles; stream shown in send order)
//   1 EN=1 x16, bits 0100 0011 0010 0001, then EN=0 -> VALUE_BCD_OUT=16'h1234, one VALID, BUSY low after.
//   2 10 bits EN=1 then EN=0 -> one FRAME_ERROR, VALUE_BCD_OUT stays 16'h1234, no VALID.
//   3 17 bits EN=1 -> FRAME_ERROR on 17th sample, WAIT_LOW; next good 0x0567 frame -> VALID, 16'h0567.
//   4 frame for 0x12A4 (digit 1 = 1010) -> one DIGIT_ERROR, output unchanged.
//   5 RST for 1 cycle after 8 bits of a frame -> all outputs 0; next full 0x9876 frame -> VALID, 16'h9876.
//   6 back-to-back frames 0x0001/0x9999 with 16 idle bits -> two VALIDs, final output 16'h9999.

Source files
------------

// File: rtl/display_receiver_module_if.sv
// Serial display link bundle: the three serial lines from the transmitter
// plus the decoded results presented by the receiver.
interface display_receiver_module_if #(
    parameter int WORDS = 4
);
    logic                 VALUE_SIGNAL;
    logic                 ENABLE_SIGNAL;
    logic                 DATA_CLOCK_SIGNAL;
    logic [4*WORDS-1:0]   VALUE_BCD_OUT;
    logic                 VALID;
    logic                 FRAME_ERROR;
    logic                 DIGIT_ERROR;
    logic                 BUSY;

    modport master (
        output VALUE_SIGNAL, ENABLE_SIGNAL, DATA_CLOCK_SIGNAL,
        input  VALUE_BCD_OUT, VALID, FRAME_ERROR, DIGIT_ERROR, BUSY
    );

    modport slave (
        input  VALUE_SIGNAL, ENABLE_SIGNAL, DATA_CLOCK_SIGNAL,
        output VALUE_BCD_OUT, VALID, FRAME_ERROR, DIGIT_ERROR, BUSY
    );
endinterface

// File: rtl/display_receiver_module.sv
// Receiver for the serial BCD display link. Synchronizes the serial lines,
// samples on bit-clock falling edges, rebuilds the BCD word, checks frame
// length and digit range, and reports the outcome with one-cycle strobes.
module display_receiver_module #(
    parameter int WORDS       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      internal_clock,
    input  logic                      RST,
    display_receiver_module_if.slave  link
);
    localparam int N  = 4 * WORDS;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RECV     = 2'd1,
        DONE     = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_valSync;
    logic [SYNC_STAGES-1:0] r_enSync;
    logic [SYNC_STAGES-1:0] r_clkSync;
    logic                   r_clkPrev;
    logic                   r_sampleEvt;
    logic                   r_dataD;
    logic                   r_enD;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [CW-1:0]          r_cnt;
    logic [N-1:0]           r_shift;
    logic [N-1:0]           r_value;
    logic                   r_valid;
    logic                   r_frameErr;
    logic                   r_digitErr;

    logic                   w_fall;
    logic [CW-1:0]          w_bitIdx;
    logic                   w_digitsOk;
    logic                   w_store;
    logic                   w_cntClear;
    logic                   w_validSet;
    logic                   w_frameErrSet;
    logic                   w_digitErrSet;

    // Bit k of a frame lands at digit k/4, MSB first inside the digit.
    assign w_bitIdx = {r_cnt[CW-1:2], ~r_cnt[1:0]};
    assign w_fall   = r_clkPrev & ~r_clkSync[SYNC_STAGES-1];

    // Bring the asynchronous serial lines into the internal clock domain.
    always_ff @(posedge internal_clock) begin
        if (RST) begin
            r_valSync <= '0;
            r_enSync  <= '0;
            r_clkSync <= '0;
        end else begin
            r_valSync <= {r_valSync[SYNC_STAGES-2:0], link.VALUE_SIGNAL};
            r_enSync  <= {r_enSync[SYNC_STAGES-2:0],  link.ENABLE_SIGNAL};
            r_clkSync <= {r_clkSync[SYNC_STAGES-2:0], link.DATA_CLOCK_SIGNAL};
        end
    end

    // Detect bit-clock falls and latch the data/enable seen at that moment.
    always_ff @(posedge internal_clock) begin
        if (RST) begin
            r_clkPrev   <= 1'b0;
            r_sampleEvt <= 1'b0;
            r_dataD     <= 1'b0;
            r_enD       <= 1'b0;
        end else begin
            r_clkPrev   <= r_clkSync[SYNC_STAGES-1];
            r_sampleEvt <= w_fall;
            r_dataD     <= r_valSync[SYNC_STAGES-1];
            r_enD       <= r_enSync[SYNC_STAGES-1];
        end
    end

    // A completed frame is only published if every digit is a decimal digit.
    always_comb begin
        w_digitsOk = 1'b1;
        for (int d = 0; d < WORDS; d++) begin
            if (r_shift[4*d +: 4] > 4'd9) begin
                w_digitsOk = 1'b0;
            end
        end
    end

    // Frame state register.
    always_ff @(posedge internal_clock) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decision, taken only on sample events.
    always_comb begin
        w_nextState = r_state;
        if (r_sampleEvt) begin
            case (r_state)
                IDLE: begin
                    if (r_enD) begin
                        w_nextState = RECV;
                    end
                end
                RECV: begin
                    if (!r_enD) begin
                        w_nextState = IDLE;
                    end else if (r_cnt == CW'(N - 1)) begin
                        w_nextState = DONE;
                    end
                end
                DONE: begin
                    w_nextState = r_enD ? WAIT_LOW : IDLE;
                end
                WAIT_LOW: begin
                    if (!r_enD) begin
                        w_nextState = IDLE;
                    end
                end
                default: w_nextState = IDLE;
            endcase
        end
    end

    // Per-state datapath controls and outcome decisions.
    always_comb begin
        w_store       = 1'b0;
        w_cntClear    = 1'b0;
        w_validSet    = 1'b0;
        w_frameErrSet = 1'b0;
        w_digitErrSet = 1'b0;
        if (r_sampleEvt) begin
            case (r_state)
                IDLE: begin
                    w_store = r_enD;
                end
                RECV: begin
                    if (r_enD) begin
                        w_store = 1'b1;
                    end else begin
                        w_frameErrSet = 1'b1;
                        w_cntClear    = 1'b1;
                    end
                end
                DONE: begin
                    if (r_enD) begin
                        w_frameErrSet = 1'b1;
                    end else begin
                        w_validSet    = w_digitsOk;
                        w_digitErrSet = ~w_digitsOk;
                        w_cntClear    = 1'b1;
                    end
                end
                WAIT_LOW: begin
                    w_cntClear = ~r_enD;
                end
                default: w_cntClear = 1'b1;
            endcase
        end
    end

    // Bit counter, shift register, published word and outcome strobes.
    always_ff @(posedge internal_clock) begin
        if (RST) begin
            r_cnt      <= '0;
            r_shift    <= '0;
            r_value    <= '0;
            r_valid    <= 1'b0;
            r_frameErr <= 1'b0;
            r_digitErr <= 1'b0;
        end else begin
            r_valid    <= w_validSet;
            r_frameErr <= w_frameErrSet;
            r_digitErr <= w_digitErrSet;
            if (w_cntClear) begin
                r_cnt <= '0;
            end else if (w_store) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_store) begin
                for (int i = 0; i < N; i++) begin
                    if (w_bitIdx == CW'(i)) begin
                        r_shift[i] <= r_dataD;
                    end
                end
            end
            if (w_validSet) begin
                r_value <= r_shift;
            end
        end
    end

    assign link.VALUE_BCD_OUT = r_value;
    assign link.VALID         = r_valid;
    assign link.FRAME_ERROR   = r_frameErr;
    assign link.DIGIT_ERROR   = r_digitErr;
    assign link.BUSY          = (r_state != IDLE);

endmodule

// File: tb/tb_display_receiver_module.sv
// Scoreboard bench for display_receiver_module: a frame-level transmitter
// pushes the expected outcome of each frame, a monitor pops on every strobe.
module tb_display_receiver_module;
    localparam int WORDS       = 4;
    localparam int N           = 4 * WORDS;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 8;

    typedef struct {
        int          kind;
        logic [15:0] value;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    exp_t        sbQ[$];
    int          numChecks = 0;
    int          numFails  = 0;
    int          cycleCnt  = 0;
    int          lastFall  = 0;
    logic [15:0] modelValue = '0;

    display_receiver_module_if #(.WORDS(WORDS)) link();

    display_receiver_module #(
        .WORDS(WORDS),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .internal_clock(clk),
        .RST(rst),
        .link(link.slave)
    );

    // Free-running system clock and cycle counter for latency checks.
    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        numChecks++;
        if (actual != expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic bit digitsOk(input logic [15:0] w);
        for (int d = 0; d < WORDS; d++) begin
            if (w[4*d +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Send order: digit 0 first, MSB first within each digit.
    function automatic logic streamBit(input logic [15:0] w, input int k);
        int idx;
        idx = (3 - (k % 4)) + (k / 4) * 4;
        return w[idx[3:0]];
    endfunction

    task automatic sendBit(input logic en, input logic val);
        @(posedge clk);
        #1;
        link.DATA_CLOCK_SIGNAL = 1'b1;
        link.ENABLE_SIGNAL     = en;
        link.VALUE_SIGNAL      = val;
        repeat (HALF) @(posedge clk);
        #1;
        link.DATA_CLOCK_SIGNAL = 1'b0;
        lastFall = cycleCnt;
        repeat (HALF - 1) @(posedge clk);
    endtask

    task automatic waitDrain(input string name);
        int t;
        t = 0;
        while (sbQ.size() != 0 && t < 40) begin
            @(posedge clk);
            t++;
        end
        checkOutput(name, sbQ.size(), 0);
        sbQ.delete();
    endtask

    // Frame of nbits enabled bits followed by one disabled sample.
    task automatic applyStimulus(input logic [15:0] word, input int nbits, input string name);
        exp_t e;
        if (nbits == N && digitsOk(word)) begin
            modelValue = word;
            e.kind = 0;
        end else if (nbits == N) begin
            e.kind = 2;
        end else begin
            e.kind = 1;
        end
        e.value = modelValue;
        sbQ.push_back(e);
        for (int k = 0; k < nbits; k++) begin
            if (k < N) sendBit(1'b1, streamBit(word, k));
            else       sendBit(1'b1, 1'($urandom));
        end
        sendBit(1'b0, 1'($urandom));
        waitDrain(name);
    endtask

    // Monitor: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        int   n;
        int   kind;
        exp_t e;
        if (!rst) begin
            n = int'(link.VALID) + int'(link.FRAME_ERROR) + int'(link.DIGIT_ERROR);
            if (n != 0) begin
                checkOutput("pulse_onehot", n, 1);
                kind = link.VALID ? 0 : (link.FRAME_ERROR ? 1 : 2);
                if (sbQ.size() == 0) begin
                    numChecks++;
                    numFails++;
                    $display("[TB] FAIL unexpected_event: got kind %0d, expected none", kind);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("event_kind", kind, e.kind);
                    checkOutput("event_value", link.VALUE_BCD_OUT, e.value);
                    checkOutput("event_latency", cycleCnt - lastFall, SYNC_STAGES + 2);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] w;
        int          r;
        int          len;
        link.VALUE_SIGNAL      = 1'b0;
        link.ENABLE_SIGNAL     = 1'b0;
        link.DATA_CLOCK_SIGNAL = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_value", link.VALUE_BCD_OUT, 0);
        checkOutput("reset_strobes", {link.VALID, link.FRAME_ERROR, link.DIGIT_ERROR}, 0);
        checkOutput("reset_busy", link.BUSY, 0);

        $display("[TB] test 1: good frame 0x1234");
        applyStimulus(16'h1234, N, "t1_drain");
        checkOutput("t1_value", link.VALUE_BCD_OUT, 16'h1234);
        checkOutput("t1_busy_low", link.BUSY, 0);

        $display("[TB] test 2: short frame");
        applyStimulus(16'h5A5A, 10, "t2_drain");
        checkOutput("t2_value_held", link.VALUE_BCD_OUT, 16'h1234);

        $display("[TB] test 3: long frame then good frame");
        applyStimulus(16'h4321, N + 1, "t3a_drain");
        applyStimulus(16'h0567, N, "t3b_drain");
        checkOutput("t3_value", link.VALUE_BCD_OUT, 16'h0567);

        $display("[TB] test 4: bad digit");
        applyStimulus(16'h12A4, N, "t4_drain");
        checkOutput("t4_value_held", link.VALUE_BCD_OUT, 16'h0567);

        $display("[TB] test 5: reset mid-frame");
        for (int k = 0; k < 8; k++) sendBit(1'b1, streamBit(16'h3333, k));
        checkOutput("t5_busy_mid", link.BUSY, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        modelValue = '0;
        @(negedge clk);
        checkOutput("t5_reset_value", link.VALUE_BCD_OUT, 0);
        checkOutput("t5_reset_busy", link.BUSY, 0);
        checkOutput("t5_reset_strobes", {link.VALID, link.FRAME_ERROR, link.DIGIT_ERROR}, 0);
        sendBit(1'b0, 1'b0);
        applyStimulus(16'h9876, N, "t5_drain");
        checkOutput("t5_value", link.VALUE_BCD_OUT, 16'h9876);

        $display("[TB] test 6: frames separated by idle bits");
        applyStimulus(16'h0001, N, "t6a_drain");
        repeat (16) sendBit(1'b0, 1'b0);
        applyStimulus(16'h9999, N, "t6b_drain");
        checkOutput("t6_value", link.VALUE_BCD_OUT, 16'h9999);

        $display("[TB] random frames");
        for (int it = 0; it < 12; it++) begin
            r = int'($urandom_range(0, 9));
            for (int d = 0; d < WORDS; d++) w[4*d +: 4] = 4'($urandom_range(0, 9));
            if (r < 2)      len = int'($urandom_range(1, N - 1));
            else if (r < 4) len = int'($urandom_range(N + 1, N + 3));
            else            len = N;
            if (r == 9) w[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            applyStimulus(w, len, "rand_drain");
            checkOutput("rand_value", link.VALUE_BCD_OUT, modelValue);
            repeat ($urandom_range(0, 2)) sendBit(1'b0, 1'b0);
        end

        repeat (20) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end
endmodule
